mc_mainfsm_stall: RTL and testbench

Parametrised main control FSM for the next-generation multicycle ARM core. It replaces the fixed-timing main decoder inside the controller. New behaviour:
- Variable-latency memory: wait states via a MemReady handshake.
- Bus-timeout fault state.
- Saturating performance counters (cycles, retired instructions, stall cycles).

Its outputs drive the datapath mux selects and the condition-logic strobes.

---
 rtl/mc_mainfsm_stall_pkg.sv | 25 ++
 rtl/mc_mainfsm_stall_if.sv | 22 ++
 rtl/mc_perf_counters.sv | 33 +++
 rtl/mc_mainfsm_stall.sv | 116 +++++++++++
 tb/tb_mc_mainfsm_stall.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_mainfsm_stall_pkg.sv
// Shared types and constants for the multicycle main-control FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FAULT    = 4'd10
  } state_e;

  localparam logic [1:0] SRCA_RD1 = 2'b00, SRCA_PC = 2'b01, SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
  localparam logic       ADR_PC = 1'b0, ADR_ALUOUT = 1'b1;

  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UND = 2'b11;

endpackage

// File: rtl/mc_mainfsm_stall_if.sv
// Instruction/memory handshake and control-output bundle of the main FSM.
interface mc_mainfsm_stall_if #(parameter int CNT_W = 32);
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             MemReady;
  logic             MemReq, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc;
  logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc;
  logic             Fault;
  logic [CNT_W-1:0] CycleCnt, RetireCnt, StallCnt;

  modport master (
    output Op, Funct, MemReady,
    input  MemReq, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, Fault, CycleCnt, RetireCnt, StallCnt
  );

  modport slave (
    input  Op, Funct, MemReady,
    output MemReq, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, Fault, CycleCnt, RetireCnt, StallCnt
  );
endinterface

// File: rtl/mc_perf_counters.sv
// Three saturating performance counters: cycles, retired instructions, stalls.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cyc_en_i,
  input  logic             ret_en_i,
  input  logic             stl_en_i,
  output logic [CNT_W-1:0] cyc_o,
  output logic [CNT_W-1:0] ret_o,
  output logic [CNT_W-1:0] stl_o
);
  logic [2:0]            en;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  assign en = {stl_en_i, ret_en_i, cyc_en_i};

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++)
      if (en[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cyc_o = cnt_q[0];
  assign ret_o = cnt_q[1];
  assign stl_o = cnt_q[2];
endmodule

// File: rtl/mc_mainfsm_stall.sv
// Main control FSM of the multicycle core with memory wait states,
// bus-timeout fault and performance counters.
module mc_mainfsm_stall
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  mc_mainfsm_stall_if.slave  bus
);
  localparam int WW = $clog2(TIMEOUT + 2);

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            fault_q, fault_d;
  logic            req_s, irw_s, npc_s, regw_s, memw_s, br_s;
  logic            alu_op, adr, waiting, timeout, retire;
  logic [1:0]      srca, srcb, res;
  logic            unused_funct;

  assign unused_funct = ^bus.Funct[4:1];

  always_comb begin
    state_d = state_q;
    {req_s, irw_s, npc_s, regw_s, memw_s, br_s} = '0;
    alu_op  = 1'b0;
    adr     = ADR_PC;
    srca    = SRCA_RD1;
    srcb    = SRCB_RD2;
    res     = RES_ALUOUT;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        req_s = 1'b1; srca = SRCA_PC; srcb = SRCB_FOUR; res = RES_ALURES;
        irw_s = bus.MemReady; npc_s = bus.MemReady;
        if (bus.MemReady) state_d = DECODE;
      end
      DECODE: begin
        srca = SRCA_PC; srcb = SRCB_FOUR; res = RES_ALURES;
        case (bus.Op)
          OP_DP:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: begin state_d = FETCH; retire = 1'b1; end
        endcase
      end
      MEMADR:   begin srcb = SRCB_IMM; state_d = bus.Funct[0] ? MEMREAD : MEMWRITE; end
      MEMREAD: begin
        req_s = 1'b1; adr = ADR_ALUOUT;
        if (bus.MemReady) state_d = MEMWB;
      end
      MEMWB:    begin res = RES_DATA; regw_s = 1'b1; state_d = FETCH; retire = 1'b1; end
      MEMWRITE: begin
        req_s = 1'b1; adr = ADR_ALUOUT; memw_s = 1'b1;
        if (bus.MemReady) begin state_d = FETCH; retire = 1'b1; end
      end
      EXECUTER: begin alu_op = 1'b1; state_d = ALUWB; end
      EXECUTEI: begin alu_op = 1'b1; srcb = SRCB_IMM; state_d = ALUWB; end
      ALUWB:    begin regw_s = 1'b1; state_d = FETCH; retire = 1'b1; end
      BRANCH: begin
        srca = SRCA_ALUOUT; srcb = SRCB_IMM; res = RES_ALURES; br_s = 1'b1;
        state_d = FETCH; retire = 1'b1;
      end
      FAULT:    state_d = FAULT;
      default:  state_d = FETCH;
    endcase

    // A completing access on the last allowed wait cycle wins over the timeout.
    waiting = req_s && !bus.MemReady;
    timeout = (TIMEOUT > 0) && waiting && (wait_q == WW'(TIMEOUT - 1));
    if (timeout) state_d = FAULT;
    fault_d = fault_q | timeout;

    if (bus.MemReady || (state_d != state_q)) wait_d = '0;
    else if (waiting)                         wait_d = wait_q + 1'b1;
    else                                      wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk      (clk),
    .reset    (reset),
    .cyc_en_i (1'b1),
    .ret_en_i (retire),
    .stl_en_i (waiting),
    .cyc_o    (bus.CycleCnt),
    .ret_o    (bus.RetireCnt),
    .stl_o    (bus.StallCnt)
  );

  assign bus.MemReq    = req_s  & ~reset;
  assign bus.IRWrite   = irw_s  & ~reset;
  assign bus.NextPC    = npc_s  & ~reset;
  assign bus.RegW      = regw_s & ~reset;
  assign bus.MemW      = memw_s & ~reset;
  assign bus.Branch    = br_s   & ~reset;
  assign bus.ALUOp     = alu_op;
  assign bus.AdrSrc    = adr;
  assign bus.ALUSrcA   = srca;
  assign bus.ALUSrcB   = srcb;
  assign bus.ResultSrc = res;
  assign bus.Fault     = fault_q;
endmodule

// File: tb/tb_mc_mainfsm_stall.sv
// Bench for mc_mainfsm_stall: directed vector table, timeout/saturation
// sequences, and random traffic against an instruction-level reference model.
module tb_mc_mainfsm_stall;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  mc_mainfsm_stall_if #(.CNT_W(32)) if0();
  mc_mainfsm_stall_if #(.CNT_W(3))  if1();

  mc_mainfsm_stall #(.TIMEOUT(4),  .CNT_W(32)) dut0 (.clk(clk), .reset(rst0), .bus(if0));
  mc_mainfsm_stall #(.TIMEOUT(16), .CNT_W(3))  dut1 (.clk(clk), .reset(rst1), .bus(if1));

  int tests = 0, fails = 0;

  // {MemReq,IRWrite,NextPC,RegW, MemW,Branch,ALUOp,AdrSrc, SrcA,SrcB,ResultSrc}
  localparam logic [13:0] E_RSTF = 14'b0000_0000_011010;
  localparam logic [13:0] E_FR   = 14'b1110_0000_011010;
  localparam logic [13:0] E_FW   = 14'b1000_0000_011010;
  localparam logic [13:0] E_DEC  = 14'b0000_0000_011010;
  localparam logic [13:0] E_MA   = 14'b0000_0000_000100;
  localparam logic [13:0] E_MR   = 14'b1000_0001_000000;
  localparam logic [13:0] E_MWB  = 14'b0001_0000_000001;
  localparam logic [13:0] E_MW   = 14'b1000_1001_000000;
  localparam logic [13:0] E_EXR  = 14'b0000_0010_000000;
  localparam logic [13:0] E_EXI  = 14'b0000_0010_000100;
  localparam logic [13:0] E_AWB  = 14'b0001_0000_000000;
  localparam logic [13:0] E_BR   = 14'b0000_0100_100110;
  localparam logic [13:0] E_FLT  = 14'b0000_0000_000000;

  localparam logic [5:0] F_ADD = 6'b001000, F_ADDI = 6'b101000;
  localparam logic [5:0] F_LDR = 6'b011001, F_STR  = 6'b011000;

  logic [13:0] o0, o1;
  assign o0 = {if0.MemReq, if0.IRWrite, if0.NextPC, if0.RegW, if0.MemW, if0.Branch,
               if0.ALUOp, if0.AdrSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ResultSrc};
  assign o1 = {if1.MemReq, if1.IRWrite, if1.NextPC, if1.RegW, if1.MemW, if1.Branch,
               if1.ALUOp, if1.AdrSrc, if1.ALUSrcA, if1.ALUSrcB, if1.ResultSrc};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step0(input bit r, input logic [1:0] op, input logic [5:0] fn, input bit rdy);
    @(negedge clk);
    rst0 = r; if0.Op = op; if0.Funct = fn; if0.MemReady = rdy;
    #1;
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  op;
    logic [5:0]  fn;
    bit          rdy;
    logic [13:0] exp;
    int          ret, cyc, stl;
  } vec_t;
  vec_t tv[$];

  task automatic addv(input bit r, input logic [1:0] op, input logic [5:0] fn, input bit rdy,
                      input logic [13:0] e, input int ret, input int cyc, input int stl);
    vec_t t;
    t.rst = r; t.op = op; t.fn = fn; t.rdy = rdy; t.exp = e;
    t.ret = ret; t.cyc = cyc; t.stl = stl;
    tv.push_back(t);
  endtask

  // Reference model: current step plus a queue of the instruction's remaining steps.
  localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
  localparam int SER = 6, SEI = 7, SAW = 8, SB = 9, SX = 10;
  localparam int TO0 = 4;
  int     m_step, m_waits;
  int     m_rest[$];
  bit     m_fault;
  longint m_cyc, m_ret, m_stl;

  function automatic logic [13:0] m_out(input int s, input bit rdy, input bit r);
    logic [13:0] e;
    case (s)
      SF:      e = rdy ? E_FR : E_FW;
      SD:      e = E_DEC;
      SMA:     e = E_MA;
      SMR:     e = E_MR;
      SMWB:    e = E_MWB;
      SMW:     e = E_MW;
      SER:     e = E_EXR;
      SEI:     e = E_EXI;
      SAW:     e = E_AWB;
      SB:      e = E_BR;
      default: e = E_FLT;
    endcase
    if (r) e[13:8] = '0;
    return e;
  endfunction

  task automatic m_reset();
    m_step = SF; m_rest.delete(); m_waits = 0; m_fault = 1'b0;
    m_cyc = 0; m_ret = 0; m_stl = 0;
  endtask

  task automatic m_advance(input bit r, input logic [1:0] op, input logic [5:0] fn, input bit rdy);
    if (r) begin m_reset(); return; end
    m_cyc++;
    if ((m_step == SF || m_step == SMR || m_step == SMW) && !rdy) begin
      m_stl++;
      m_waits++;
      if (m_waits == TO0) begin m_step = SX; m_fault = 1'b1; m_waits = 0; end
    end else if (m_step != SX) begin
      m_waits = 0;
      if (m_step == SF) m_step = SD;
      else begin
        if (m_step == SD) begin
          case (op)
            2'b00: m_rest = '{fn[5] ? SEI : SER, SAW};
            2'b01: m_rest = fn[0] ? '{SMA, SMR, SMWB} : '{SMA, SMW};
            2'b10: m_rest = '{SB};
            default: m_rest.delete();
          endcase
        end
        if (m_rest.size() == 0) begin m_ret++; m_step = SF; end
        else m_step = m_rest.pop_front();
      end
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    bit         rr, rrdy;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.Op = 2'b00; if0.Funct = F_ADD; if0.MemReady = 1'b1;
    if1.Op = 2'b10; if1.Funct = 6'd0;  if1.MemReady = 1'b1;

    addv(1, 2'b00, F_ADD,  1, E_RSTF, 0, 0, 0);
    addv(0, 2'b00, F_ADD,  1, E_FR,   0, 0, 0);
    addv(0, 2'b00, F_ADD,  1, E_DEC,  0, 1, 0);
    addv(0, 2'b00, F_ADD,  1, E_EXR,  0, 2, 0);
    addv(0, 2'b00, F_ADD,  1, E_AWB,  0, 3, 0);
    addv(0, 2'b01, F_LDR,  1, E_FR,   1, 4, 0);
    addv(0, 2'b01, F_LDR,  1, E_DEC,  1, 5, 0);
    addv(0, 2'b01, F_LDR,  1, E_MA,   1, 6, 0);
    addv(0, 2'b01, F_LDR,  0, E_MR,   1, 7, 0);
    addv(0, 2'b01, F_LDR,  0, E_MR,   1, 8, 1);
    addv(0, 2'b01, F_LDR,  0, E_MR,   1, 9, 2);
    addv(0, 2'b01, F_LDR,  1, E_MR,   1, 10, 3);
    addv(0, 2'b01, F_LDR,  1, E_MWB,  1, 11, 3);
    addv(0, 2'b01, F_STR,  0, E_FW,   2, 12, 3);
    addv(0, 2'b01, F_STR,  1, E_FR,   2, 13, 4);
    addv(0, 2'b01, F_STR,  1, E_DEC,  2, 14, 4);
    addv(0, 2'b01, F_STR,  1, E_MA,   2, 15, 4);
    addv(0, 2'b01, F_STR,  0, E_MW,   2, 16, 4);
    addv(0, 2'b01, F_STR,  0, E_MW,   2, 17, 5);
    addv(0, 2'b01, F_STR,  1, E_MW,   2, 18, 6);
    addv(0, 2'b10, 6'd0,   1, E_FR,   3, 19, 6);
    addv(0, 2'b10, 6'd0,   1, E_DEC,  3, 20, 6);
    addv(0, 2'b10, 6'd0,   1, E_BR,   3, 21, 6);
    addv(0, 2'b11, 6'd0,   1, E_FR,   4, 22, 6);
    addv(0, 2'b11, 6'd0,   1, E_DEC,  4, 23, 6);
    addv(0, 2'b00, F_ADDI, 1, E_FR,   5, 24, 6);
    addv(0, 2'b00, F_ADDI, 1, E_DEC,  5, 25, 6);
    addv(0, 2'b00, F_ADDI, 1, E_EXI,  5, 26, 6);
    addv(0, 2'b00, F_ADDI, 1, E_AWB,  5, 27, 6);
    addv(0, 2'b00, F_ADD,  0, E_FW,   6, 28, 6);

    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      step0(tv[i].rst, tv[i].op, tv[i].fn, tv[i].rdy);
      chk($sformatf("vec%0d_out", i), o0, tv[i].exp);
      chk($sformatf("vec%0d_ret", i), if0.RetireCnt, tv[i].ret);
      chk($sformatf("vec%0d_cyc", i), if0.CycleCnt, tv[i].cyc);
      chk($sformatf("vec%0d_stl", i), if0.StallCnt, tv[i].stl);
      chk($sformatf("vec%0d_fault", i), if0.Fault, 1'b0);
    end

    // Timeout: four waiting FETCH cycles, FAULT on the fifth, sticky until reset.
    step0(1, 2'b00, F_ADD, 0);
    for (int k = 0; k < 4; k++) begin
      step0(0, 2'b00, F_ADD, 0);
      chk("to_wait_out", o0, E_FW);
      chk("to_wait_fault", if0.Fault, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step0(0, 2'b00, F_ADD, (k != 0));
      chk("to_fault_out", o0, E_FLT);
      chk("to_fault_flag", if0.Fault, 1'b1);
      chk("to_fault_cyc", if0.CycleCnt, 4 + k);
      chk("to_fault_stl", if0.StallCnt, 4);
    end
    step0(1, 2'b00, F_ADD, 1);
    chk("to_rst_out", o0, E_FLT);
    step0(0, 2'b00, F_ADD, 0);
    chk("to_clr_fault", if0.Fault, 1'b0);
    chk("to_clr_cyc", if0.CycleCnt, 0);
    chk("to_clr_stl", if0.StallCnt, 0);
    chk("to_clr_ret", if0.RetireCnt, 0);
    chk("to_clr_out", o0, E_FW);

    // Ready arriving on the last allowed wait cycle wins.
    for (int k = 0; k < 2; k++) begin
      step0(0, 2'b00, F_ADD, 0);
      chk("late_wait_out", o0, E_FW);
    end
    step0(0, 2'b00, F_ADD, 1);
    chk("late_ready_out", o0, E_FR);
    step0(0, 2'b00, F_ADD, 0);
    chk("late_decode_out", o0, E_DEC);
    chk("late_no_fault", if0.Fault, 1'b0);
    chk("late_stl", if0.StallCnt, 3);

    // Saturation on the narrow-counter instance: back-to-back branches.
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      rst1 = 1'b0; if1.Op = 2'b10; if1.MemReady = 1'b1;
      #1;
      chk($sformatf("sat%0d_cyc", i), if1.CycleCnt, (i > 7) ? 7 : i);
      chk($sformatf("sat%0d_ret", i), if1.RetireCnt, (i / 3 > 7) ? 7 : i / 3);
      chk($sformatf("sat%0d_stl", i), if1.StallCnt, 0);
    end
    chk("sat_branch_out", o1, E_FR);

    // Random traffic against the reference model.
    step0(1, 2'b00, F_ADD, 1);
    m_reset();
    rop = 2'b00; rfn = F_ADD;
    for (int n = 0; n < 2000; n++) begin
      if (m_step == SF) begin
        rop = 2'($urandom_range(0, 3));
        rfn = 6'($urandom);
      end
      rrdy = ($urandom_range(0, 9) < 6);
      rr   = ($urandom_range(0, 99) == 0) || (m_fault && $urandom_range(0, 3) == 0);
      step0(rr, rop, rfn, rrdy);
      chk("rnd_out", o0, m_out(m_step, rrdy, rr));
      chk("rnd_fault", if0.Fault, m_fault);
      chk("rnd_cyc", if0.CycleCnt, m_cyc);
      chk("rnd_ret", if0.RetireCnt, m_ret);
      chk("rnd_stl", if0.StallCnt, m_stl);
      m_advance(rr, rop, rfn, rrdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
